// File: rtl/lc4_arb_pkg.sv
// Shared definitions for the LC4 instruction/data memory arbiter: FSM encodings,
// requester ids, parameter defaults and the starvation-counter helper.
package lc4_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic ID_FETCH = 1'b0;
    localparam logic ID_DATA  = 1'b1;

    localparam int NUM_REQ            = 2;
    localparam int MEM_LAT_DEFAULT    = 2;
    localparam int STARVE_MAX_DEFAULT = 3;
    localparam int CTR_W              = 3;

    localparam logic [CTR_W-1:0] CTR_ONE = 1;

    function automatic logic [CTR_W-1:0] sat_inc(
        input logic [CTR_W-1:0] value,
        input logic [CTR_W-1:0] limit
    );
        logic [CTR_W-1:0] result;
        result = (value < limit) ? value + CTR_ONE : limit;
        return result;
    endfunction

endpackage

// File: rtl/Nbit_reg.sv
// Generic N-bit register with synchronous active-high reset and a write
// enable qualified by the global write enable.
module Nbit_reg #(
    parameter int           N           = 1,
    parameter logic [N-1:0] RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         gwe,
    input  logic         rst,
    input  logic         we,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Reset is deliberately not gated by gwe so a reset always abandons an access.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (gwe && we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/lc4_arb_lat_ctr.sv
// Loadable down-counter tracking memory read latency; done flags the cycle in
// which read data is valid.
module lc4_arb_lat_ctr
    import lc4_arb_pkg::*;
(
    input  logic             clk,
    input  logic             gwe,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CTR_W-1:0] load_value,
    output logic             done
);

    logic [CTR_W-1:0] count_reg;
    logic [CTR_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_value;
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - CTR_ONE;
        end
    end

    Nbit_reg #(.N(CTR_W)) count_ff (
        .clk (clk),
        .gwe (gwe),
        .rst (rst),
        .we  (load | dec),
        .d   (count_next),
        .q   (count_reg)
    );

    assign done = (count_reg == CTR_ONE);

endmodule

// File: rtl/lc4_mem_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and data access,
// one outstanding access at a time, with data priority and fetch anti-starvation.
module lc4_mem_arbiter
    import lc4_arb_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gwe,
    input  logic        if_req_valid,
    input  logic [15:0] if_req_addr,
    output logic        if_rsp_valid,
    output logic [15:0] if_rsp_data,
    output logic        if_stall,
    input  logic        d_req_valid,
    input  logic        d_req_we,
    input  logic [15:0] d_req_addr,
    input  logic [15:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [15:0] d_rsp_data,
    output logic        d_stall,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata
);

    localparam logic [CTR_W-1:0] LAT_LOAD   = CTR_W'(MEM_LAT);
    localparam logic [CTR_W-1:0] STARVE_LIM = CTR_W'(STARVE_MAX);

    logic [1:0]       state_bits;
    arb_state_t       state_reg;
    arb_state_t       state_next;
    logic             winner_reg,  winner_next;
    logic [15:0]      addr_reg,    addr_next;
    logic             we_reg,      we_next;
    logic [15:0]      wdata_reg,   wdata_next;
    logic [CTR_W-1:0] starve_reg,  starve_next;
    logic [15:0]      rsp_reg,     rsp_next;

    logic fetch_wins;
    logic latch_en;
    logic capture_en;
    logic ctr_load;
    logic ctr_dec;
    logic ctr_done;
    logic mem_fire;
    logic resp_fire;

    logic [NUM_REQ-1:0] rsp_valid_vec;
    logic [15:0]        rsp_data_vec [NUM_REQ];

    // ------------------------------------------------------------------
    // State and latched-request registers
    // ------------------------------------------------------------------
    Nbit_reg #(.N(2)) state_ff (
        .clk(clk), .gwe(gwe), .rst(rst), .we(1'b1),
        .d(state_next), .q(state_bits)
    );
    assign state_reg = arb_state_t'(state_bits);

    Nbit_reg #(.N(1)) winner_ff (
        .clk(clk), .gwe(gwe), .rst(rst), .we(latch_en),
        .d(winner_next), .q(winner_reg)
    );

    Nbit_reg #(.N(16)) addr_ff (
        .clk(clk), .gwe(gwe), .rst(rst), .we(latch_en),
        .d(addr_next), .q(addr_reg)
    );

    Nbit_reg #(.N(1)) we_ff (
        .clk(clk), .gwe(gwe), .rst(rst), .we(latch_en),
        .d(we_next), .q(we_reg)
    );

    Nbit_reg #(.N(16)) wdata_ff (
        .clk(clk), .gwe(gwe), .rst(rst), .we(latch_en),
        .d(wdata_next), .q(wdata_reg)
    );

    Nbit_reg #(.N(CTR_W)) starve_ff (
        .clk(clk), .gwe(gwe), .rst(rst), .we(latch_en),
        .d(starve_next), .q(starve_reg)
    );

    Nbit_reg #(.N(16)) rsp_ff (
        .clk(clk), .gwe(gwe), .rst(rst), .we(capture_en),
        .d(rsp_next), .q(rsp_reg)
    );

    lc4_arb_lat_ctr lat_ctr (
        .clk        (clk),
        .gwe        (gwe),
        .rst        (rst),
        .load       (ctr_load),
        .dec        (ctr_dec),
        .load_value (LAT_LOAD),
        .done       (ctr_done)
    );

    // ------------------------------------------------------------------
    // Next-state and arbitration
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        latch_en   = 1'b0;
        capture_en = 1'b0;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;

        // Data wins by default; fetch only when alone or after STARVE_MAX losses.
        fetch_wins  = if_req_valid && (!d_req_valid || (starve_reg == STARVE_LIM));
        winner_next = fetch_wins ? ID_FETCH : ID_DATA;
        addr_next   = fetch_wins ? if_req_addr : d_req_addr;
        we_next     = !fetch_wins && d_req_we;
        wdata_next  = fetch_wins ? 16'h0000 : d_req_wdata;
        if (fetch_wins) begin
            starve_next = '0;
        end else if (if_req_valid) begin
            starve_next = sat_inc(starve_reg, STARVE_LIM);
        end else begin
            starve_next = starve_reg;
        end
        rsp_next = we_reg ? 16'h0000 : i_mem_rdata;

        case (state_reg)
            ST_IDLE: begin
                if (if_req_valid || d_req_valid) begin
                    latch_en   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ctr_load   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                ctr_dec = 1'b1;
                if (ctr_done) begin
                    capture_en = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: strobes are suppressed while gwe is low or reset is held so a
    // stalled cycle never produces a duplicate access or response.
    // ------------------------------------------------------------------
    always_comb begin
        mem_fire    = (state_reg == ST_ISSUE) && gwe && !rst;
        resp_fire   = (state_reg == ST_RESP) && gwe && !rst;
        o_mem_en    = mem_fire;
        o_mem_we    = mem_fire && we_reg;
        o_mem_addr  = mem_fire ? addr_reg : 16'h0000;
        o_mem_wdata = (mem_fire && we_reg) ? wdata_reg : 16'h0000;
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid_vec[gi] = resp_fire && (winner_reg == 1'(gi));
            assign rsp_data_vec[gi]  = rsp_valid_vec[gi] ? rsp_reg : 16'h0000;
        end
    endgenerate

    assign if_rsp_valid = rsp_valid_vec[ID_FETCH];
    assign if_rsp_data  = rsp_data_vec[ID_FETCH];
    assign d_rsp_valid  = rsp_valid_vec[ID_DATA];
    assign d_rsp_data   = rsp_data_vec[ID_DATA];
    assign if_stall     = if_req_valid && !if_rsp_valid;
    assign d_stall      = d_req_valid && !d_rsp_valid;

endmodule

// File: tb/tb_lc4_mem_arbiter.sv
// Directed bench for lc4_mem_arbiter with a gwe-aware fixed-latency memory model
// and a monitor that logs every access and response.
module tb_lc4_mem_arbiter;

    localparam int TB_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        gwe;
    logic        if_req_valid;
    logic [15:0] if_req_addr;
    logic        if_rsp_valid;
    logic [15:0] if_rsp_data;
    logic        if_stall;
    logic        d_req_valid;
    logic        d_req_we;
    logic [15:0] d_req_addr;
    logic [15:0] d_req_wdata;
    logic        d_rsp_valid;
    logic [15:0] d_rsp_data;
    logic        d_stall;
    logic        o_mem_en;
    logic        o_mem_we;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic [15:0] i_mem_rdata;

    lc4_mem_arbiter #(.MEM_LAT(TB_LAT), .STARVE_MAX(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .gwe          (gwe),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .if_stall     (if_stall),
        .d_req_valid  (d_req_valid),
        .d_req_we     (d_req_we),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .d_stall      (d_stall),
        .o_mem_en     (o_mem_en),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 clk = ~clk;

    int check_count = 0;
    int error_count = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory contents: a few fixed words, everything else a simple address hash.
    function automatic logic [15:0] mem_read(input logic [15:0] a);
        logic [15:0] r;
        case (a)
            16'h8200: r = 16'h1234;
            16'h4000: r = 16'hCAFE;
            16'h8201: r = 16'h9001;
            default:  r = a ^ 16'h5A5A;
        endcase
        return r;
    endfunction

    // Memory model: data valid exactly TB_LAT gwe-enabled cycles after o_mem_en, junk otherwise.
    logic [TB_LAT-1:0] pend = '0;
    logic [15:0]       pend_addr [TB_LAT];

    always @(posedge clk) begin
        if (gwe) begin
            pend[0]      <= o_mem_en;
            pend[1]      <= pend[0];
            pend_addr[0] <= o_mem_addr;
            pend_addr[1] <= pend_addr[0];
        end
    end

    assign i_mem_rdata = pend[1] ? mem_read(pend_addr[1]) : 16'hDEAD;

    // Cycle counter and transaction logs
    int cyc_now = 0;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    int          en_total = 0;
    int          if_total = 0;
    int          d_total  = 0;
    int          en_cyc   [64];
    logic [15:0] en_addr  [64];
    logic        en_we    [64];
    logic [15:0] en_wdata [64];
    int          if_cyc   [64];
    logic [15:0] if_data  [64];
    int          d_cyc    [64];
    logic [15:0] d_data   [64];

    always @(negedge clk) begin
        if (o_mem_en && en_total < 64) begin
            en_cyc[en_total]   <= cyc_now;
            en_addr[en_total]  <= o_mem_addr;
            en_we[en_total]    <= o_mem_we;
            en_wdata[en_total] <= o_mem_wdata;
            en_total           <= en_total + 1;
            $display("[%0d] mem access addr=%h we=%b wdata=%h", cyc_now, o_mem_addr, o_mem_we, o_mem_wdata);
        end
        if (if_rsp_valid && if_total < 64) begin
            if_cyc[if_total]  <= cyc_now;
            if_data[if_total] <= if_rsp_data;
            if_total          <= if_total + 1;
            $display("[%0d] fetch response data=%h", cyc_now, if_rsp_data);
        end
        if (d_rsp_valid && d_total < 64) begin
            d_cyc[d_total]  <= cyc_now;
            d_data[d_total] <= d_rsp_data;
            d_total         <= d_total + 1;
            $display("[%0d] data response data=%h", cyc_now, d_rsp_data);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        gwe          = 1'b1;
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        d_req_we     = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    int          base;
    int          e0;
    int          i0;
    int          d0;
    logic [7:0]  exp_seq;

    task automatic mark();
        base = cyc_now;
        e0   = en_total;
        i0   = if_total;
        d0   = d_total;
    endtask

    initial begin
        rst = 1'b1; gwe = 1'b1;
        if_req_valid = 1'b0; if_req_addr = 16'h0000;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 16'h0000; d_req_wdata = 16'h0000;

        // Reset state
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_val("rst_mem_en",   32'(o_mem_en),     32'd0);
        check_val("rst_mem_addr", 32'(o_mem_addr),   32'd0);
        check_val("rst_if_rsp",   32'(if_rsp_valid), 32'd0);
        check_val("rst_d_rsp",    32'(d_rsp_valid),  32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        check_val("idle_mem_en", 32'(o_mem_en), 32'd0);
        check_val("idle_if_stall", 32'(if_stall), 32'd0);
        next_cycle();

        // Fetch only
        mark();
        if_req_valid = 1'b1; if_req_addr = 16'h8200;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) if_req_valid = 1'b0;
            @(negedge clk);
            check_val($sformatf("t1_if_stall_c%0d", c), 32'(if_stall), 32'(c <= 3));
            next_cycle();
        end
        check_val("t1_en_count", 32'(en_total - e0), 32'd1);
        check_val("t1_en_cyc",   32'(en_cyc[e0] - base), 32'd1);
        check_val("t1_en_addr",  32'(en_addr[e0]), 32'h8200);
        check_val("t1_en_we",    32'(en_we[e0]), 32'd0);
        check_val("t1_en_wdata", 32'(en_wdata[e0]), 32'd0);
        check_val("t1_if_count", 32'(if_total - i0), 32'd1);
        check_val("t1_if_cyc",   32'(if_cyc[i0] - base), 32'd4);
        check_val("t1_if_data",  32'(if_data[i0]), 32'h1234);
        check_val("t1_d_count",  32'(d_total - d0), 32'd0);

        // Fetch and load together: data first
        do_reset();
        mark();
        if_req_valid = 1'b1; if_req_addr = 16'h8201;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 16'h4000;
        for (int c = 0; c < 12; c++) begin
            if (c == 5)  d_req_valid = 1'b0;
            if (c == 10) if_req_valid = 1'b0;
            next_cycle();
        end
        check_val("t2_en_count",  32'(en_total - e0), 32'd2);
        check_val("t2_en0_addr",  32'(en_addr[e0]), 32'h4000);
        check_val("t2_en0_cyc",   32'(en_cyc[e0] - base), 32'd1);
        check_val("t2_en1_addr",  32'(en_addr[e0+1]), 32'h8201);
        check_val("t2_en1_cyc",   32'(en_cyc[e0+1] - base), 32'd6);
        check_val("t2_d_cyc",     32'(d_cyc[d0] - base), 32'd4);
        check_val("t2_d_data",    32'(d_data[d0]), 32'hCAFE);
        check_val("t2_if_cyc",    32'(if_cyc[i0] - base), 32'd9);
        check_val("t2_if_data",   32'(if_data[i0]), 32'h9001);
        check_val("t2_counts",    32'((if_total - i0) * 16 + (d_total - d0)), 32'h11);

        // Store
        do_reset();
        mark();
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 16'h4010; d_req_wdata = 16'hBEEF;
        for (int c = 0; c < 8; c++) begin
            if (c == 5) d_req_valid = 1'b0;
            next_cycle();
        end
        d_req_we = 1'b0;
        check_val("t3_en_count", 32'(en_total - e0), 32'd1);
        check_val("t3_en_cyc",   32'(en_cyc[e0] - base), 32'd1);
        check_val("t3_en_addr",  32'(en_addr[e0]), 32'h4010);
        check_val("t3_en_we",    32'(en_we[e0]), 32'd1);
        check_val("t3_en_wdata", 32'(en_wdata[e0]), 32'hBEEF);
        check_val("t3_d_count",  32'(d_total - d0), 32'd1);
        check_val("t3_d_cyc",    32'(d_cyc[d0] - base), 32'd4);
        check_val("t3_d_data",   32'(d_data[d0]), 32'h0000);
        check_val("t3_if_count", 32'(if_total - i0), 32'd0);

        // Both held valid: D,D,D,I,D,D,D,I
        do_reset();
        mark();
        exp_seq = 8'b1000_1000;
        if_req_valid = 1'b1; if_req_addr = 16'h8040;
        d_req_valid = 1'b1; d_req_addr = 16'h4020;
        for (int c = 0; c < 44; c++) begin
            if (c == 40) begin
                if_req_valid = 1'b0;
                d_req_valid  = 1'b0;
            end
            next_cycle();
        end
        check_val("t4_en_count", 32'(en_total - e0), 32'd8);
        for (int g = 0; g < 8; g++) begin
            check_val($sformatf("t4_grant%0d_fetch", g), 32'(en_addr[e0+g][15]), 32'(exp_seq[g]));
            check_val($sformatf("t4_grant%0d_cyc", g), 32'(en_cyc[e0+g] - base), 32'(1 + 5 * g));
        end

        // Reset mid-load, then a fetch right after
        do_reset();
        mark();
        d_req_valid = 1'b1; d_req_addr = 16'h4000;
        for (int c = 0; c < 11; c++) begin
            if (c == 2) rst = 1'b1;
            if (c == 3) begin
                rst = 1'b0;
                d_req_valid  = 1'b0;
                if_req_valid = 1'b1;
                if_req_addr  = 16'h8300;
            end
            if (c == 8) if_req_valid = 1'b0;
            @(negedge clk);
            if (c == 2) check_val("t5_rst_d_rsp", 32'(d_rsp_valid), 32'd0);
            if (c == 3) check_val("t5_post_rst_addr", 32'(o_mem_addr), 32'd0);
            next_cycle();
        end
        check_val("t5_d_count",  32'(d_total - d0), 32'd0);
        check_val("t5_en_count", 32'(en_total - e0), 32'd2);
        check_val("t5_en1_cyc",  32'(en_cyc[e0+1] - base), 32'd4);
        check_val("t5_en1_addr", 32'(en_addr[e0+1]), 32'h8300);
        check_val("t5_if_count", 32'(if_total - i0), 32'd1);
        check_val("t5_if_cyc",   32'(if_cyc[i0] - base), 32'd7);
        check_val("t5_if_data",  32'(if_data[i0]), 32'hD95A);

        // gwe low for cycles 2-4 of a load
        do_reset();
        mark();
        d_req_valid = 1'b1; d_req_addr = 16'h4000;
        for (int c = 0; c < 11; c++) begin
            if (c == 2) gwe = 1'b0;
            if (c == 5) gwe = 1'b1;
            if (c == 8) d_req_valid = 1'b0;
            next_cycle();
        end
        check_val("t6_en_count", 32'(en_total - e0), 32'd1);
        check_val("t6_en_cyc",   32'(en_cyc[e0] - base), 32'd1);
        check_val("t6_d_count",  32'(d_total - d0), 32'd1);
        check_val("t6_d_cyc",    32'(d_cyc[d0] - base), 32'd7);
        check_val("t6_d_data",   32'(d_data[d0]), 32'hCAFE);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
